// File: rtl/srff_pkg.sv
// Shared mode encoding for the srff_bank register bank and its per-bit cell.
package srff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SR = 2'b00;
  localparam mode_t MODE_JK = 2'b01;
  localparam mode_t MODE_D  = 2'b10;
  localparam mode_t MODE_T  = 2'b11;

endpackage

// File: rtl/srff_cell.sv
// Single-bit next-state and forbidden-input detect for the SR/JK/D/T bank.
module srff_cell
  import srff_pkg::*;
(
  input  logic  q,
  input  logic  s,
  input  logic  r,
  input  mode_t mode,
  output logic  q_next,
  output logic  illegal
);

  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    unique case (mode)
      MODE_SR: begin
        // S=R=1 holds the bit and reports the forbidden combination
        if (s && r)  illegal = 1'b1;
        else if (s)  q_next  = 1'b1;
        else if (r)  q_next  = 1'b0;
      end
      MODE_JK: begin
        if (s && r)  q_next = ~q;
        else if (s)  q_next = 1'b1;
        else if (r)  q_next = 1'b0;
      end
      MODE_D:  q_next = s;
      MODE_T:  q_next = q ^ s;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/srff_bank.sv
// WIDTH-bit SR/JK/D/T flip-flop bank with sticky illegal-input flags.
// Define SRFF_BANK_ERR_COUNT_EN to add the saturating err_cnt output.
module srff_bank
  import srff_pkg::*;
#(
  parameter int                 WIDTH      = 8,
  parameter logic [WIDTH-1:0]   PRESET_VAL = {WIDTH{1'b1}}
`ifdef SRFF_BANK_ERR_COUNT_EN
  ,
  parameter int                 CNT_W      = 8
`endif
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             preset,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] illegal_flag,
`ifdef SRFF_BANK_ERR_COUNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic             illegal_any
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic [WIDTH-1:0] cell_next, cell_ill;
  logic [WIDTH-1:0] ill_evt;
  logic             evt_any;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    srff_cell u_cell (
      .q      (q_q[i]),
      .s      (s[i]),
      .r      (r[i]),
      .mode   (mode),
      .q_next (cell_next[i]),
      .illegal(cell_ill[i])
    );
  end

  // Illegal events only count on edges that would actually update q
  assign ill_evt = (en && preset) ? cell_ill : '0;
  assign evt_any = |ill_evt;

  always_comb begin
    q_d    = q_q;
    flag_d = flag_clr ? '0 : flag_q;
    if (!preset)   q_d = PRESET_VAL;
    else if (en)   q_d = cell_next;
    flag_d = flag_d | ill_evt;
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      q_q    <= '0;
      flag_q <= '0;
    end else begin
      q_q    <= q_d;
      flag_q <= flag_d;
    end
  end

`ifdef SRFF_BANK_ERR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One count per edge with any event; saturates instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (flag_clr)                      cnt_d = evt_any ? CNT_W'(1) : '0;
    else if (evt_any && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clear) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_cnt = cnt_q;
`else
  logic unused_evt;
  assign unused_evt = evt_any;
`endif

  assign q            = q_q;
  assign qbar         = ~q_q;
  assign illegal_flag = flag_q;
  assign illegal_any  = |flag_q;

endmodule

// File: tb/tb_srff_bank.sv
// Directed self-checking bench for srff_bank (checks err_cnt when SRFF_BANK_ERR_COUNT_EN is defined).
module tb_srff_bank;
  import srff_pkg::*;

  logic       clk = 1'b0;
  logic       clear, preset, en, flag_clr;
  mode_t      mode;
  logic [7:0] s, r;
  logic [7:0] q, qbar, illegal_flag;
  logic       illegal_any;
`ifdef SRFF_BANK_ERR_COUNT_EN
  logic [1:0] err_cnt;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

`ifdef SRFF_BANK_ERR_COUNT_EN
  srff_bank #(.WIDTH(8), .PRESET_VAL(8'hFF), .CNT_W(2)) dut (
`else
  srff_bank #(.WIDTH(8), .PRESET_VAL(8'hFF)) dut (
`endif
    .clk         (clk),
    .clear       (clear),
    .preset      (preset),
    .en          (en),
    .mode        (mode),
    .s           (s),
    .r           (r),
    .flag_clr    (flag_clr),
    .q           (q),
    .qbar        (qbar),
    .illegal_flag(illegal_flag),
`ifdef SRFF_BANK_ERR_COUNT_EN
    .err_cnt     (err_cnt),
`endif
    .illegal_any (illegal_any)
  );

  // Drives one edge's worth of inputs, then samples just after the edge
  task automatic applyStimulus(input logic c, input logic p, input logic e,
                               input mode_t m, input logic [7:0] sv,
                               input logic [7:0] rv, input logic fc);
    @(negedge clk);
    clear = c; preset = p; en = e; mode = m; s = sv; r = rv; flag_clr = fc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkCnt(input string tag, input int exp);
`ifdef SRFF_BANK_ERR_COUNT_EN
    checkOutput(tag, 32'(err_cnt), 32'(exp));
`else
    if (exp < 0) $display("[TB] %s unused", tag);
`endif
  endtask

  initial begin
    clear = 1'b1; preset = 1'b1; en = 1'b0; mode = MODE_SR;
    s = '0; r = '0; flag_clr = 1'b0;

    applyStimulus(0, 0, 1, MODE_SR, 8'hFF, 8'h00, 0);
    checkOutput("reset q", q, 8'h00);
    checkOutput("reset qbar", qbar, 8'hFF);
    checkOutput("reset flag", illegal_flag, 8'h00);
    checkOutput("reset any", illegal_any, 1'b0);
    checkCnt("reset cnt", 0);

    applyStimulus(1, 0, 1, MODE_SR, 8'h00, 8'hFF, 0);
    checkOutput("preset q", q, 8'hFF);

    applyStimulus(1, 1, 1, MODE_SR, 8'h00, 8'hFF, 0);
    checkOutput("sr reset all", q, 8'h00);
    applyStimulus(1, 1, 1, MODE_SR, 8'h0F, 8'hF0, 0);
    checkOutput("sr set", q, 8'h0F);
    checkOutput("sr qbar", qbar, 8'hF0);

    applyStimulus(1, 1, 1, MODE_SR, 8'h81, 8'h81, 0);
    checkOutput("sr illegal hold", q, 8'h0F);
    checkOutput("sr illegal flag", illegal_flag, 8'h81);
    checkOutput("sr illegal any", illegal_any, 1'b1);
    checkCnt("sr illegal cnt", 1);

    applyStimulus(1, 1, 1, MODE_JK, 8'hAA, 8'hAA, 0);
    checkOutput("jk toggle", q, 8'hA5);
    checkOutput("jk no flag", illegal_flag, 8'h81);
    applyStimulus(1, 1, 1, MODE_T, 8'hFF, 8'h00, 0);
    checkOutput("t toggle", q, 8'h5A);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, MODE_SR, 8'hFF, 8'hFF, 0);
      checkOutput("en low hold", q, 8'h5A);
    end
    checkOutput("en low no flag", illegal_flag, 8'h81);
    checkCnt("en low cnt", 1);

    applyStimulus(1, 1, 1, MODE_D, 8'h3C, 8'hFF, 0);
    checkOutput("d load", q, 8'h3C);
    applyStimulus(1, 1, 1, MODE_T, 8'h01, 8'hFF, 0);
    checkOutput("t after d", q, 8'h3D);

    applyStimulus(1, 1, 1, MODE_SR, 8'h02, 8'h02, 1);
    checkOutput("clr collide flag", illegal_flag, 8'h02);
    checkOutput("clr collide q", q, 8'h3D);
    checkCnt("clr collide cnt", 1);

    applyStimulus(1, 1, 0, MODE_SR, 8'h00, 8'h00, 1);
    checkOutput("flag_clr flag", illegal_flag, 8'h00);
    checkOutput("flag_clr any", illegal_any, 1'b0);
    checkCnt("flag_clr cnt", 0);

    applyStimulus(1, 0, 1, MODE_SR, 8'hFF, 8'hFF, 0);
    checkOutput("preset beats en", q, 8'hFF);
    checkOutput("preset no event", illegal_flag, 8'h00);
    checkCnt("preset no cnt", 0);

    applyStimulus(0, 1, 1, MODE_D, 8'hAA, 8'h00, 0);
    checkOutput("clear override", q, 8'h00);

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 1, 1, MODE_SR, 8'h01, 8'h01, 0);
      checkOutput("sat q", q, 8'h00);
      checkOutput("sat flag", illegal_flag, 8'h01);
      checkCnt("sat cnt", (i > 3) ? 3 : i);
    end

    applyStimulus(0, 1, 1, MODE_SR, 8'h01, 8'h01, 0);
    checkOutput("final clear flag", illegal_flag, 8'h00);
    checkOutput("final clear any", illegal_any, 1'b0);
    checkCnt("final clear cnt", 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/srff_bank.md
Name: srff_bank

Overview:
- Parametrised successor to the single-bit gated SR flip-flop.
- WIDTH independent storage bits share one clock, one mode select, an enable, a synchronous preset and a synchronous clear.
- Runtime-selectable SR/JK/D/T next-state behaviour per bank.
- Detects forbidden S=R=1 in SR mode with sticky per-bit flags; an optional counter counts these events.
- Used as a control/status register bank in the lab test designs.

Parameters:
- WIDTH, 8, number of flip-flop bits.
- PRESET_VAL, {WIDTH{1'b1}}, value loaded into q on preset.
- CNT_W, 8, width of the illegal-event counter (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- preset  input  1  synchronous active-low preset; loads PRESET_VAL.
- en  input  1  clock enable; high = update q per mode.
- mode  input  2  00=SR, 01=JK, 10=D, 11=T.
- s  input  WIDTH  per-bit S / J / D / T input, depending on mode.
- r  input  WIDTH  per-bit R / K input; ignored in D and T modes.
- flag_clr  input  1  synchronous clear of illegal_flag and err_cnt.
- q  output  WIDTH  stored state.
- qbar  output  WIDTH  always ~q, combinational from q.
- illegal_flag  output  WIDTH  sticky; bit i set when SR mode saw s[i]=r[i]=1 with en high.
- illegal_any  output  1  OR-reduction of illegal_flag.

Behaviour:
- All state updates occur on the rising edge of clk.
- Reset is synchronous and active-low: clear is sampled only on the rising edge of clk.
- Priority per edge: clear low > preset low > en high > hold.
- On clear low:
  - q = 0, qbar = all ones, illegal_flag = 0, illegal_any = 0, err_cnt = 0.
  - Clear mid-operation overrides any pending update that edge.
- On preset low (clear high):
  - q = PRESET_VAL.
  - illegal_flag is not modified and no illegal events are recorded that edge.
- Simultaneous clear and preset low: clear wins, q = 0.
- en low (clear and preset high): q holds, no flags set.
- en high, next state per bit i:
  - SR: s=0,r=0 hold; s=1,r=0 set; s=0,r=1 reset; s=1,r=1 hold q[i] and set illegal_flag[i].
  - JK: 00 hold; 10 set; 01 reset; 11 toggle. No illegal condition.
  - D: q[i] = s[i].
  - T: q[i] = q[i] ^ s[i].
- Latency: q reflects inputs one edge after sampling. qbar is the same cycle as q.
- mode may change every cycle; the value sampled at the edge applies.
- illegal_flag:
  - Cleared by clear low or flag_clr high.
  - If flag_clr and a new illegal event occur on the same edge, the new event wins: the bit is set.
- illegal_any: combinational OR of illegal_flag.

Optional Feature:
- Macro: SRFF_BANK_ERR_COUNT_EN.
- Defined:
  - Adds output port err_cnt [CNT_W-1:0].
  - Counts edges on which at least one bit raised an illegal event; +1 per edge regardless of how many bits.
  - Saturates at all ones, no wrap.
  - Reset to 0 by clear low or flag_clr high. A flag_clr edge that also has an illegal event loads 1.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package srff_pkg holds:
  - Mode localparams MODE_SR=2'b00, MODE_JK=2'b01, MODE_D=2'b10, MODE_T=2'b11.
  - A mode_t 2-bit typedef.
- Sub-module srff_cell:
  - Single-bit combinational next-state and illegal-detect logic: inputs q, s, r, mode, outputs q_next, illegal.
  - Instantiated WIDTH times via generate.
  - The registers, priority logic and counter stay in srff_bank.

Test Plan:
- Reset and preset:
  - clear=0 with preset=0, s=8'hFF, en=1 -> q=8'h00, qbar=8'hFF, illegal_flag=0.
  - Next edge with clear=1, preset=0 -> q=PRESET_VAL=8'hFF.
- SR mode:
  - q=8'h00, s=8'h0F, r=8'hF0, en=1 -> q=8'h0F.
  - Then s=8'h81, r=8'h81 -> q=8'h0F held, illegal_flag=8'h81, illegal_any=1, err_cnt=1.
- JK/T toggle:
  - JK with s=r=8'hAA from q=8'h0F -> q=8'hA5.
  - T with s=8'hFF -> q=8'h5A.
  - en=0 for 3 edges -> q stays 8'h5A.
- D mode and mode switch per cycle:
  - Edge 1: D, s=8'h3C -> q=8'h3C.
  - Edge 2: T, s=8'h01 -> q=8'h3D.
  - r is ignored throughout (drive 8'hFF).
- flag_clr collision:
  - illegal_flag=8'h81; flag_clr=1 and SR s=r=8'h02 same edge -> illegal_flag=8'h02, err_cnt=1.
- Counter saturation (feature on, CNT_W=2):
  - 5 consecutive illegal edges -> err_cnt 1,2,3,3,3.
  - clear=0 -> err_cnt=0, flags 0.
